// File: rtl/bp_me_pkg.sv
// Shared BedRock memory-message types and command-FSM encoding for the
// cache DMA concentrator.
package bp_me_pkg;

   localparam int paddr_width_gp   = 40;
   localparam int mem_payload_w_gp = 16;

   typedef enum logic [1:0] {
      e_cmd_idle  = 2'd0,
      e_cmd_hdr   = 2'd1,
      e_cmd_wdata = 2'd2
   } cmd_state_e;

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3
   } bp_bedrock_mem_type_e;

   typedef enum logic [3:0] {
      e_bedrock_store   = 4'd0,
      e_bedrock_amoswap = 4'd1,
      e_bedrock_amoadd  = 4'd2
   } bp_bedrock_wr_subop_e;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1   = 3'd0,
      e_bedrock_msg_size_2   = 3'd1,
      e_bedrock_msg_size_4   = 3'd2,
      e_bedrock_msg_size_8   = 3'd3,
      e_bedrock_msg_size_16  = 3'd4,
      e_bedrock_msg_size_32  = 3'd5,
      e_bedrock_msg_size_64  = 3'd6,
      e_bedrock_msg_size_128 = 3'd7
   } bp_bedrock_msg_size_e;

   typedef struct packed {
      logic [mem_payload_w_gp-1:0] payload;
      bp_bedrock_msg_size_e        size;
      logic [paddr_width_gp-1:0]   addr;
      bp_bedrock_wr_subop_e        subop;
      bp_bedrock_mem_type_e        msg_type;
   } bp_bedrock_mem_header_s;

   localparam int cce_mem_msg_header_width_gp = $bits(bp_bedrock_mem_header_s);

   function automatic bp_bedrock_msg_size_e bp_block_bytes_to_msg_size(input int bytes);
      case (bytes)
         8:       return e_bedrock_msg_size_8;
         16:      return e_bedrock_msg_size_16;
         32:      return e_bedrock_msg_size_32;
         64:      return e_bedrock_msg_size_64;
         default: return e_bedrock_msg_size_128;
      endcase
   endfunction

endpackage

// File: rtl/bp_me_dma_tag_fifo.sv
// In-order FIFO of issuing-bank tags for outstanding reads; push and pop may
// coincide even when full.
module bp_me_dma_tag_fifo #(
   parameter int width_p = 1,
   parameter int els_p   = 4
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] data_i,
   input  logic               push_i,
   input  logic               pop_i,
   output logic [width_p-1:0] data_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);
   localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(els_p - 1);

   logic [els_p-1:0][width_p-1:0] mem_r;
   logic [ptr_w_lp-1:0]           wptr_r, rptr_r;
   logic [cnt_w_lp-1:0]           cnt_r;
   logic                          do_push, do_pop;

   assign full_o  = (cnt_r == cnt_w_lp'(els_p));
   assign empty_o = (cnt_r == '0);
   assign data_o  = mem_r[rptr_r];
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mem_r  <= '0;
         wptr_r <= '0;
         rptr_r <= '0;
         cnt_r  <= '0;
      end else begin
         if (do_push) begin
            mem_r[wptr_r] <= data_i;
            wptr_r        <= (wptr_r == ptr_last_lp) ? '0 : wptr_r + 1'b1;
         end
         if (do_pop)
            rptr_r <= (rptr_r == ptr_last_lp) ? '0 : rptr_r + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_r <= cnt_r + 1'b1;
            2'b01:   cnt_r <= cnt_r - 1'b1;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

endmodule

// File: rtl/bp_me_cache_dma_mux.sv
// Concentrates per-bank cache DMA channels onto one BedRock memory stream and
// steers in-order read fills back to the issuing bank.
module bp_me_cache_dma_mux
   import bp_me_pkg::*;
#(
   parameter  int num_banks_p           = 2,
   parameter  int caddr_width_p         = 28,
   parameter  int data_width_p          = 64,
   parameter  int block_size_in_words_p = 8,
   parameter  int max_reads_p           = 4,
   localparam int dma_pkt_width_lp      = caddr_width_p + 1,
   localparam int hdr_width_lp          = cce_mem_msg_header_width_gp
) (
   input  logic                                   clk_i,
   input  logic                                   reset_n_i,
   input  logic [num_banks_p*dma_pkt_width_lp-1:0] dma_pkt_i,
   input  logic [num_banks_p-1:0]                 dma_pkt_v_i,
   output logic [num_banks_p-1:0]                 dma_pkt_yumi_o,
   input  logic [num_banks_p*data_width_p-1:0]    dma_data_i,
   input  logic [num_banks_p-1:0]                 dma_data_v_i,
   output logic [num_banks_p-1:0]                 dma_data_yumi_o,
   output logic [data_width_p-1:0]                dma_data_o,
   output logic [num_banks_p-1:0]                 dma_data_v_o,
   input  logic [num_banks_p-1:0]                 dma_data_ready_i,
   output logic [hdr_width_lp-1:0]                mem_cmd_header_o,
   output logic                                   mem_cmd_header_v_o,
   input  logic                                   mem_cmd_header_yumi_i,
   output logic [data_width_p-1:0]                mem_cmd_data_o,
   output logic                                   mem_cmd_data_v_o,
   input  logic                                   mem_cmd_data_yumi_i,
   input  logic [hdr_width_lp-1:0]                mem_resp_header_i,
   input  logic                                   mem_resp_header_v_i,
   output logic                                   mem_resp_header_ready_o,
   input  logic [data_width_p-1:0]                mem_resp_data_i,
   input  logic                                   mem_resp_data_v_i,
   output logic                                   mem_resp_data_ready_o
);

   localparam int tag_w_lp = (num_banks_p > 1) ? $clog2(num_banks_p) : 1;
   localparam int cnt_w_lp = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;
   localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(block_size_in_words_p - 1);
   localparam logic [tag_w_lp-1:0] last_bank_lp = tag_w_lp'(num_banks_p - 1);
   localparam bp_bedrock_msg_size_e size_lp =
      bp_block_bytes_to_msg_size(block_size_in_words_p * data_width_p / 8);

   logic [num_banks_p-1:0][dma_pkt_width_lp-1:0] pkt_a;
   logic [num_banks_p-1:0][data_width_p-1:0]     wdata_a;
   assign pkt_a   = dma_pkt_i;
   assign wdata_a = dma_data_i;

   cmd_state_e             state_r;
   bp_bedrock_mem_header_s hdr_r;
   logic                   hdr_v_r;
   logic [tag_w_lp-1:0]    bank_r, rr_r, grant_id, sel, head;
   logic [cnt_w_lp-1:0]    wcnt_r, rcnt_r;
   logic                   grant_v, fifo_full, fifo_empty, fifo_push, fifo_pop, resp_fire;
   int                     idx;

   // Walk from the highest offset down so the bank nearest rr_r wins.
   always_comb begin
      grant_v  = 1'b0;
      grant_id = '0;
      idx      = 0;
      sel      = '0;
      for (int i = num_banks_p - 1; i >= 0; i--) begin
         idx = int'(rr_r) + i;
         if (idx >= num_banks_p) idx = idx - num_banks_p;
         sel = tag_w_lp'(idx);
         if (dma_pkt_v_i[sel] && (pkt_a[sel][dma_pkt_width_lp-1] || !fifo_full)) begin
            grant_v  = 1'b1;
            grant_id = sel;
         end
      end
   end

   always_comb begin
      dma_pkt_yumi_o  = '0;
      dma_data_yumi_o = '0;
      dma_data_v_o    = '0;
      if (state_r == e_cmd_idle && grant_v && reset_n_i) dma_pkt_yumi_o[grant_id] = 1'b1;
      if (state_r == e_cmd_wdata) dma_data_yumi_o[bank_r] = mem_cmd_data_yumi_i;
      if (!fifo_empty) dma_data_v_o[head] = mem_resp_data_v_i;
   end

   assign mem_cmd_header_o        = hdr_r;
   assign mem_cmd_header_v_o      = hdr_v_r;
   assign mem_cmd_data_o          = wdata_a[bank_r];
   assign mem_cmd_data_v_o        = (state_r == e_cmd_wdata) & dma_data_v_i[bank_r];
   assign mem_resp_header_ready_o = 1'b1;
   assign mem_resp_data_ready_o   = ~fifo_empty & dma_data_ready_i[head];
   assign dma_data_o              = mem_resp_data_i;

   assign resp_fire = mem_resp_data_v_i & mem_resp_data_ready_o;
   assign fifo_pop  = resp_fire & (rcnt_r == last_beat_lp);
   assign fifo_push = hdr_v_r & mem_cmd_header_yumi_i & (hdr_r.msg_type == e_bedrock_mem_rd);

   // Response headers carry nothing needed here; memory returns reads in order.
   logic unused_resp;
   assign unused_resp = ^{mem_resp_header_i, mem_resp_header_v_i};

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= e_cmd_idle;
         hdr_r   <= '0;
         hdr_v_r <= 1'b0;
         bank_r  <= '0;
         rr_r    <= '0;
         wcnt_r  <= '0;
      end else begin
         case (state_r)
            e_cmd_idle: if (grant_v) begin
               state_r        <= e_cmd_hdr;
               hdr_v_r        <= 1'b1;
               bank_r         <= grant_id;
               rr_r           <= (grant_id == last_bank_lp) ? '0 : grant_id + 1'b1;
               hdr_r.msg_type <= pkt_a[grant_id][dma_pkt_width_lp-1] ? e_bedrock_mem_wr : e_bedrock_mem_rd;
               hdr_r.subop    <= e_bedrock_store;
               hdr_r.size     <= size_lp;
               hdr_r.addr     <= paddr_width_gp'(pkt_a[grant_id][caddr_width_p-1:0]);
               hdr_r.payload  <= '0;
            end
            e_cmd_hdr: if (mem_cmd_header_yumi_i) begin
               hdr_v_r <= 1'b0;
               wcnt_r  <= '0;
               state_r <= (hdr_r.msg_type == e_bedrock_mem_wr) ? e_cmd_wdata : e_cmd_idle;
            end
            e_cmd_wdata: if (mem_cmd_data_yumi_i) begin
               wcnt_r <= wcnt_r + 1'b1;
               if (wcnt_r == last_beat_lp) state_r <= e_cmd_idle;
            end
            default: state_r <= e_cmd_idle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         rcnt_r <= '0;
      else if (resp_fire)
         rcnt_r <= (rcnt_r == last_beat_lp) ? '0 : rcnt_r + 1'b1;
   end

   bp_me_dma_tag_fifo #(
      .width_p (tag_w_lp),
      .els_p   (max_reads_p)
   ) u_tag_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (bank_r),
      .push_i    (fifo_push),
      .pop_i     (fifo_pop),
      .data_o    (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

endmodule
